fir_filter_mc: RTL and testbench
================================

// Module: fir_filter_mc
// PURPOSE
//   Multi-channel, time-multiplexed FIR filter. It is the successor to the fixed-coefficient
//   8-tap FIR filter wrapper, and adds runtime-loadable coefficients, NUM_CHANNELS independent
//   sample histories and valid/ready input flow control.
//   A single sequential MAC is shared by all channels. It sits between a sample source
//   (ADC/demo stimulus) and the downstream sink.
// PARAMETERS
//   DATA_WIDTH    16  signed sample width
//   COEFF_WIDTH   16  signed coefficient width
//   NUM_TAPS      8   taps per channel (>=2)
//   NUM_CHANNELS  4   independent channels (>=1)
//   OUTPUT_WIDTH  DATA_WIDTH+COEFF_WIDTH+$clog2(NUM_TAPS)  signed result width
// PORTS
//   clk          in   1                        clock; all logic rising-edge
//   resetn       in   1                        asynchronous, active-low reset
//   coeff_we     in   1                        coefficient write strobe
//   coeff_addr   in   $clog2(NUM_TAPS)         tap index written
//   coeff_wdata  in   COEFF_WIDTH              signed coefficient value
//   coeff_busy   out  1                        1 = coefficient writes are dropped
//   in_valid     in   1                        sample offered
//   in_ready     out  1                        sample accepted when in_valid&&in_ready
//   in_chan      in   max(1,$clog2(NUM_CHANNELS))  channel of offered sample
//   x            in   DATA_WIDTH               signed sample
//   out_valid    out  1                        one-cycle result strobe
//   out_chan     out  max(1,$clog2(NUM_CHANNELS))  channel of y
//   y            out  OUTPUT_WIDTH             signed filter output
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - All coefficients and all channel histories are 0.
//   - y=0, out_valid=0, out_chan=0, state=IDLE, in_ready=1, coeff_busy=0.
//   Output equation:
//   - y = sum_k c[k]*h[chan][k] for k=0..NUM_TAPS-1, where h[chan][0] is the newest sample.
//   - Products are signed full precision. The sum is sign-extended to OUTPUT_WIDTH and never
//     overflows or saturates.
//   FSM state IDLE:
//   - in_ready=1, coeff_busy=0.
//   - On accept at cycle T: shift x into h[in_chan], latch in_chan, clear the accumulator,
//     then go to MAC.
//   FSM state MAC:
//   - Runs for cycles T+1..T+NUM_TAPS. At step k the block adds c[k]*h[chan][k].
//   - in_ready=0, coeff_busy=1.
//   FSM state OUT:
//   - Cycle T+NUM_TAPS+1: out_valid=1, y and out_chan updated. y holds its value until the
//     next OUT.
//   - Returns to IDLE next cycle.
//   - Latency is NUM_TAPS+1 cycles from accept to out_valid. Max throughput is one sample per
//     NUM_TAPS+2 cycles.
//   No output backpressure:
//   - The sink must take y while out_valid=1.
//   - out_valid is 0 in all states except OUT.
//   Coefficient writes:
//   - A write in IDLE takes effect next cycle.
//   - A write in the same cycle as a sample accept commits and is used by that sample.
//   - A write while coeff_busy=1 is silently dropped.
//   - Coefficients are shared by all channels.
//   in_chan >= NUM_CHANNELS:
//   - The sample is accepted (handshake completes) but dropped. No history changes, no MAC,
//     no out_valid. The FSM stays IDLE.
//   Channel isolation:
//   - Only h[in_chan] shifts. All other histories are untouched.
//   Reset mid-operation:
//   - Aborts the computation; no out_valid for that sample.
//   - All coefficients and histories are cleared.
//   x/in_chan are sampled only on accept and may change freely otherwise.
// TESTING
//   1. Load c={1,2,4,8,8,4,2,1} (c[0]=1). Drive ch0 impulse x=1, then 8 zeros
//      -> y=1,2,4,8,8,4,2,1,0, out_chan=0, each strobe NUM_TAPS+1=9 cycles after its accept.
//   2. Same coeffs. Interleave ch0 impulse with ch1 constant x=100
//      -> ch1 y=100,300,700,1500,2300,2700,2900,3000 while ch0 matches test 1.
//   3. Set all c=-32768. Drive 8 ch2 samples x=-32768 -> last y=+8589934592 (2^33) with no
//      wrap. Then x=32767 x8 with c=-32768 -> y=-8589672448.
//   4. Pulse coeff_we during MAC (coeff_busy=1) -> write dropped and y unchanged. Repeat the
//      write on the accept cycle -> the new coefficient is used for that sample.
//   5. Assert resetn=0 mid-MAC -> out_valid never pulses, in_ready=1 after release. Impulse
//      with unloaded coeffs -> y=0.
//   6. Hold in_valid=1 continuously -> in_ready high exactly 1 of every 10 cycles
//      (NUM_TAPS=8). in_chan=5 with NUM_CHANNELS=4 -> accepted, no out_valid.

Source files
------------

// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed FIR: one shared sequential MAC, runtime-loadable shared
// coefficients, one sample history per channel, valid/ready input and a one-cycle result strobe.
module fir_filter_mc #(
    parameter int DATA_WIDTH   = 16,
    parameter int COEFF_WIDTH  = 16,
    parameter int NUM_TAPS     = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int OUTPUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS),
    parameter int CHAN_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int TAP_WIDTH    = $clog2(NUM_TAPS)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           coeff_we,
    input  logic [TAP_WIDTH-1:0]           coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0]  coeff_wdata,
    output logic                           coeff_busy,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHAN_WIDTH-1:0]          in_chan,
    input  logic signed [DATA_WIDTH-1:0]   x,
    output logic                           out_valid,
    output logic [CHAN_WIDTH-1:0]          out_chan,
    output logic signed [OUTPUT_WIDTH-1:0] y
);
    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam logic [CHAN_WIDTH:0]  NCH      = (CHAN_WIDTH+1)'(NUM_CHANNELS);
    localparam logic [TAP_WIDTH-1:0] LAST_TAP = TAP_WIDTH'(NUM_TAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                          state;
    logic signed [COEFF_WIDTH-1:0]   coeff [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]    hist  [NUM_CHANNELS][NUM_TAPS];
    logic [CHAN_WIDTH-1:0]           chan;
    logic [TAP_WIDTH-1:0]            tap;
    logic signed [OUTPUT_WIDTH-1:0]  acc;
    logic signed [PW-1:0]            prod;
    logic signed [OUTPUT_WIDTH-1:0]  sum;
    logic                            accept;
    logic                            chan_ok;

    assign accept  = in_valid && in_ready;
    // Out-of-range channels complete the handshake but are otherwise ignored.
    assign chan_ok = {1'b0, in_chan} < NCH;
    assign prod    = coeff[tap] * hist[chan][tap];
    assign sum     = acc + {{(OUTPUT_WIDTH-PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            coeff_busy <= 1'b0;
            out_valid  <= 1'b0;
            out_chan   <= '0;
            y          <= '0;
            acc        <= '0;
            chan       <= '0;
            tap        <= '0;
            for (int k = 0; k < NUM_TAPS; k++) coeff[k] <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int k = 0; k < NUM_TAPS; k++) hist[c][k] <= '0;
        end else begin
            out_valid <= 1'b0;
            // A write on the accept cycle lands before MAC step 0 reads the table.
            if (coeff_we && !coeff_busy) coeff[coeff_addr] <= coeff_wdata;
            case (state)
                IDLE: begin
                    if (accept && chan_ok) begin
                        for (int k = NUM_TAPS-1; k > 0; k--)
                            hist[in_chan][k] <= hist[in_chan][k-1];
                        hist[in_chan][0] <= x;
                        chan       <= in_chan;
                        acc        <= '0;
                        tap        <= '0;
                        state      <= MAC;
                        in_ready   <= 1'b0;
                        coeff_busy <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= sum;
                    tap <= tap + 1'b1;
                    if (tap == LAST_TAP) begin
                        y         <= sum;
                        out_chan  <= chan;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    state      <= IDLE;
                    in_ready   <= 1'b1;
                    coeff_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    in_ready   <= 1'b1;
                    coeff_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed bench for fir_filter_mc: hand-computed results for impulse, interleaved channels,
// full-scale extremes, coefficient write timing, reset abort, throughput and bad channels.
module tb_fir_filter_mc;
    logic               clk = 1'b0;
    logic               resetn = 1'b1;
    logic               coeff_we = 1'b0;
    logic [2:0]         coeff_addr = '0;
    logic signed [15:0] coeff_wdata = '0;
    logic               coeff_busy;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         in_chan = '0;
    logic signed [15:0] x = '0;
    logic               out_valid;
    logic [1:0]         out_chan;
    logic signed [34:0] y;
    // second instance with 5 channels so that in_chan=5 is representable
    logic               b_in_valid = 1'b0;
    logic               b_in_ready;
    logic [2:0]         b_in_chan = '0;
    logic               b_coeff_busy;
    logic               b_out_valid;
    logic [2:0]         b_out_chan;
    logic signed [34:0] b_y;

    int vectors = 0;
    int errors  = 0;
    int cv[8]   = '{1, 2, 4, 8, 8, 4, 2, 1};

    always #5 clk = ~clk;

    fir_filter_mc dut (
        .clk(clk), .resetn(resetn), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
        .coeff_wdata(coeff_wdata), .coeff_busy(coeff_busy), .in_valid(in_valid),
        .in_ready(in_ready), .in_chan(in_chan), .x(x), .out_valid(out_valid),
        .out_chan(out_chan), .y(y)
    );

    fir_filter_mc #(.NUM_CHANNELS(5)) dut_b (
        .clk(clk), .resetn(resetn), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
        .coeff_wdata(coeff_wdata), .coeff_busy(b_coeff_busy), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_chan(b_in_chan), .x(x), .out_valid(b_out_valid),
        .out_chan(b_out_chan), .y(b_y)
    );

    task automatic write_coeff(input int a, input int d);
        @(negedge clk);
        coeff_we = 1'b1; coeff_addr = a[2:0]; coeff_wdata = d[15:0];
        @(posedge clk);
        #1 coeff_we = 1'b0;
    endtask

    task automatic load_default;
        for (int k = 0; k < 8; k++) write_coeff(k, cv[k]);
    endtask

    // Offers one sample; returns right after the accepting edge.
    task automatic start_sample(input int ch, input int v, input bit we = 1'b0,
                                input int a = 0, input int d = 0);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_chan = ch[1:0]; x = v[15:0];
        if (we) begin coeff_we = 1'b1; coeff_addr = a[2:0]; coeff_wdata = d[15:0]; end
        @(posedge clk);
        #1 in_valid = 1'b0; coeff_we = 1'b0; x = 16'sh5a5a; in_chan = 2'd3;
    endtask

    // Latency counted in cycles from the accept cycle; 20 means no strobe seen.
    task automatic wait_result(output logic signed [34:0] ry, output logic [1:0] rc,
                               output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        ry = y; rc = out_chan;
    endtask

    task automatic test_reset;
        #2 resetn = 1'b0;
        @(negedge clk);
        vectors++;
        if (y !== 35'sd0 || out_valid !== 1'b0 || out_chan !== 2'd0 || in_ready !== 1'b1 ||
            coeff_busy !== 1'b0)
            begin errors++; $display("FAIL reset_hold: y=%0d ov=%0b oc=%0d rdy=%0b busy=%0b required 0/0/0/1/0",
                y, out_valid, out_chan, in_ready, coeff_busy); end
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if (y !== 35'sd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || coeff_busy !== 1'b0)
            begin errors++; $display("FAIL reset_release: y=%0d ov=%0b rdy=%0b busy=%0b required 0/0/1/0",
                y, out_valid, in_ready, coeff_busy); end
    endtask

    task automatic test_impulse;
        logic signed [34:0] ry; logic [1:0] rc; int lat; longint e;
        load_default();
        for (int i = 0; i < 9; i++) begin
            start_sample(0, (i == 0) ? 1 : 0);
            wait_result(ry, rc, lat);
            e = (i < 8) ? longint'(cv[i]) : 64'sd0;
            vectors++;
            if (longint'(ry) !== e || rc !== 2'd0 || lat != 9)
                begin errors++; $display("FAIL impulse[%0d]: y=%0d ch=%0d lat=%0d required %0d/0/9",
                    i, ry, rc, lat, e); end
            if (i == 0) begin
                @(negedge clk);
                vectors++;
                if (out_valid !== 1'b0)
                    begin errors++; $display("FAIL strobe_width: out_valid=%0b required 0", out_valid); end
            end
        end
    endtask

    task automatic test_interleave;
        logic signed [34:0] ry; logic [1:0] rc; int lat;
        int e1[8] = '{100, 300, 700, 1500, 2300, 2700, 2900, 3000};
        for (int i = 0; i < 8; i++) begin
            start_sample(0, (i == 0) ? 1 : 0);
            wait_result(ry, rc, lat);
            vectors++;
            if (longint'(ry) !== longint'(cv[i]) || rc !== 2'd0 || lat != 9)
                begin errors++; $display("FAIL interleave_ch0[%0d]: y=%0d ch=%0d lat=%0d required %0d/0/9",
                    i, ry, rc, lat, cv[i]); end
            start_sample(1, 100);
            wait_result(ry, rc, lat);
            vectors++;
            if (longint'(ry) !== longint'(e1[i]) || rc !== 2'd1 || lat != 9)
                begin errors++; $display("FAIL interleave_ch1[%0d]: y=%0d ch=%0d lat=%0d required %0d/1/9",
                    i, ry, rc, lat, e1[i]); end
        end
    endtask

    task automatic test_full_scale;
        logic signed [34:0] ry; logic [1:0] rc; int lat; longint e;
        for (int k = 0; k < 8; k++) write_coeff(k, -32768);
        for (int i = 0; i < 8; i++) begin
            start_sample(2, -32768);
            wait_result(ry, rc, lat);
            e = longint'(i + 1) * 64'sd1073741824;
            vectors++;
            if (longint'(ry) !== e || rc !== 2'd2)
                begin errors++; $display("FAIL max_pos[%0d]: y=%0d ch=%0d required %0d/2", i, ry, rc, e); end
        end
        for (int i = 1; i <= 8; i++) begin
            start_sample(2, 32767);
            wait_result(ry, rc, lat);
            e = -64'sd32768 * (64'sd32767 * i - 64'sd32768 * (8 - i));
            vectors++;
            if (longint'(ry) !== e || rc !== 2'd2)
                begin errors++; $display("FAIL max_neg[%0d]: y=%0d ch=%0d required %0d/2", i, ry, rc, e); end
        end
    endtask

    task automatic test_coeff_write;
        logic signed [34:0] ry; logic [1:0] rc; int lat;
        load_default();
        start_sample(3, 10);
        @(negedge clk);
        vectors++;
        if (coeff_busy !== 1'b1)
            begin errors++; $display("FAIL busy_in_mac: coeff_busy=%0b required 1", coeff_busy); end
        coeff_we = 1'b1; coeff_addr = 3'd0; coeff_wdata = 16'sd50;
        @(posedge clk);
        #1 coeff_we = 1'b0;
        wait_result(ry, rc, lat);
        vectors++;
        if (ry !== 35'sd10 || rc !== 2'd3)
            begin errors++; $display("FAIL write_dropped: y=%0d ch=%0d required 10/3", ry, rc); end
        start_sample(3, 3, 1'b1, 0, 50);
        wait_result(ry, rc, lat);
        vectors++;
        if (ry !== 35'sd170 || rc !== 2'd3 || lat != 9)
            begin errors++; $display("FAIL write_on_accept: y=%0d ch=%0d lat=%0d required 170/3/9", ry, rc, lat); end
    endtask

    task automatic test_reset_mid;
        logic signed [34:0] ry; logic [1:0] rc; int lat; int pulses = 0;
        start_sample(0, 5);
        @(negedge clk); @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 35'sd0)
            begin errors++; $display("FAIL reset_async: ov=%0b rdy=%0b y=%0d required 0/1/0", out_valid, in_ready, y); end
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        vectors++;
        if (pulses != 0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_abort: pulses=%0d rdy=%0b required 0/1", pulses, in_ready); end
        start_sample(0, 1);
        wait_result(ry, rc, lat);
        vectors++;
        if (ry !== 35'sd0 || rc !== 2'd0 || lat != 9)
            begin errors++; $display("FAIL cleared_coeffs: y=%0d ch=%0d lat=%0d required 0/0/9", ry, rc, lat); end
    endtask

    task automatic test_back_to_back;
        int highs = 0; int misplaced = 0;
        @(negedge clk);
        in_valid = 1'b1; in_chan = 2'd0; x = 16'sd1;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (in_ready) begin
                highs++;
                if (n % 10 != 0) misplaced++;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (highs != 4 || misplaced != 0)
            begin errors++; $display("FAIL throughput: ready_cycles=%0d misplaced=%0d required 4/0", highs, misplaced); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_bad_chan;
        int pulses = 0; int busy = 0;
        @(negedge clk);
        vectors++;
        if (b_in_ready !== 1'b1)
            begin errors++; $display("FAIL bad_chan_ready: in_ready=%0b required 1", b_in_ready); end
        b_in_valid = 1'b1; b_in_chan = 3'd5;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (b_out_valid) pulses++;
            if (!b_in_ready || b_coeff_busy) busy++;
        end
        vectors++;
        if (pulses != 0 || busy != 0)
            begin errors++; $display("FAIL bad_chan_drop: pulses=%0d busy_cycles=%0d required 0/0", pulses, busy); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_interleave();
        test_full_scale();
        test_coeff_write();
        test_reset_mid();
        test_back_to_back();
        test_bad_chan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
